// File: rtl/clk_div_pkg.sv
// Shared types and constants for the divider configuration path.
package clk_div_pkg;

    // Sender FSM: IDLE accepts a request, SETUP lets o_div settle one cycle,
    // HOLD keeps o_div frozen while the far-side clk_div samples it.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HOLD  = 2'd2
    } cfg_tx_st_e;

    // Special divide values: 0 stops the clock, 1 passes it through.
    localparam int DIV_OFF = 0;
    localparam int DIV_BYP = 1;

endpackage

// File: rtl/clk_div_ramp_step.sv
// Computes the next divide value to send when moving from cur toward target.
// Off/bypass values on either side are never ramped through.
module clk_div_ramp_step
    import clk_div_pkg::*;
#(
    parameter int DW   = 8,
    parameter int STEP = 1
) (
    input  logic [DW-1:0] cur,
    input  logic [DW-1:0] target,
    input  logic          ramp,
    output logic [DW-1:0] next_div
);

    logic [DW:0] cur_w;
    logic [DW:0] tgt_w;
    logic [DW:0] up_w;
    logic [DW:0] dn_lim_w;

    // One extra bit keeps the upward add from wrapping and lets the downward
    // path compare against target+STEP instead of subtracting below zero.
    always_comb begin
        cur_w    = {1'b0, cur};
        tgt_w    = {1'b0, target};
        up_w     = cur_w + (DW+1)'(STEP);
        dn_lim_w = tgt_w + (DW+1)'(STEP);
        next_div = target;
        if (ramp && (cur > DW'(DIV_BYP)) && (target > DW'(DIV_BYP))) begin
            if (tgt_w > cur_w) begin
                next_div = (up_w > tgt_w) ? target : up_w[DW-1:0];
            end else if (cur_w >= dn_lim_w) begin
                next_div = cur - DW'(STEP);
            end else begin
                next_div = target;
            end
        end
    end

endmodule

// File: rtl/clk_div_cfg_tx.sv
// Sending side of the clk_div configuration interface. Each value goes out as
// o_div followed one cycle later by a flip of o_div_tog, then o_div is frozen
// for HOLD_CYC cycles because clk_div returns no acknowledge.
module clk_div_cfg_tx
    import clk_div_pkg::*;
#(
    parameter int DW       = 8,
    parameter int HOLD_CYC = 8,
    parameter int STEP     = 1
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_req_vld,
    output logic          o_req_rdy,
    input  logic [DW-1:0] i_req_div,
    input  logic          i_req_ramp,
    output logic [DW-1:0] o_div,
    output logic          o_div_tog,
    output logic          o_busy
);

    localparam int CW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    cfg_tx_st_e    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [DW-1:0] target_q, target_d;
    logic          ramp_q, ramp_d;
    logic          tog_q, tog_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [DW-1:0] step_tgt;
    logic          step_ramp;
    logic [DW-1:0] step_next;

    // In IDLE the first step comes straight from the request; afterwards only
    // the latched copy is used, so busy-time changes on i_req_* are invisible.
    assign step_tgt  = (state_q == IDLE) ? i_req_div  : target_q;
    assign step_ramp = (state_q == IDLE) ? i_req_ramp : ramp_q;

    clk_div_ramp_step #(
        .DW   (DW),
        .STEP (STEP)
    ) u_step (
        .cur      (div_q),
        .target   (step_tgt),
        .ramp     (step_ramp),
        .next_div (step_next)
    );

    // State and output registers; reset drops any pending target.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= IDLE;
            div_q    <= DW'(DIV_OFF);
            target_q <= DW'(DIV_OFF);
            ramp_q   <= 1'b0;
            tog_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            target_q <= target_d;
            ramp_q   <= ramp_d;
            tog_q    <= tog_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic: o_div only moves on entry to SETUP, the toggle only on
    // leaving it, so the two never change on the same edge.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        target_d = target_q;
        ramp_d   = ramp_q;
        tog_d    = tog_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (i_req_vld) begin
                    target_d = i_req_div;
                    ramp_d   = i_req_ramp;
                    div_d    = step_next;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                tog_d   = ~tog_q;
                cnt_d   = CW'(HOLD_CYC - 1);
                state_d = HOLD;
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    if (div_q == target_q) begin
                        state_d = IDLE;
                    end else begin
                        div_d   = step_next;
                        state_d = SETUP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_div     = div_q;
    assign o_div_tog = tog_q;
    assign o_req_rdy = (state_q == IDLE);
    assign o_busy    = ~o_req_rdy;

endmodule

// File: tb/tb_clk_div_cfg_tx.sv
// Scoreboard bench for clk_div_cfg_tx: requests push the expected sequence of
// sent values and busy duration; a monitor pops them on each toggle edge.
module tb_clk_div_cfg_tx;

    localparam int DW       = 8;
    localparam int HOLD_CYC = 8;
    localparam int STEP     = 2;

    logic          clk;
    logic          rstn;
    logic          reqVld;
    logic          reqRdy;
    logic [DW-1:0] reqDiv;
    logic          reqRamp;
    logic [DW-1:0] div;
    logic          divTog;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int modelDiv = 0;
    bit inReset = 1'b1;
    int expDiv[$];
    int expBusy[$];

    clk_div_cfg_tx #(
        .DW       (DW),
        .HOLD_CYC (HOLD_CYC),
        .STEP     (STEP)
    ) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_req_vld  (reqVld),
        .o_req_rdy  (reqRdy),
        .i_req_div  (reqDiv),
        .i_req_ramp (reqRamp),
        .o_div      (div),
        .o_div_tog  (divTog),
        .o_busy     (busy)
    );

    // 100 MHz source clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it and reports a mismatch
    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: walk from cur to tgt with the ramp rules in plain
    // integer arithmetic and queue every value that should be sent.
    task automatic pushExpected(input int cur, input int tgt, input bit ramp);
        int v = cur;
        int n = 0;
        do begin
            if (!ramp || v < 2 || tgt < 2) v = tgt;
            else if (tgt > v) v = (v + STEP > tgt) ? tgt : v + STEP;
            else v = (v - STEP < tgt) ? tgt : v - STEP;
            expDiv.push_back(v);
            n++;
        end while (v != tgt);
        expBusy.push_back(n * (HOLD_CYC + 1));
    endtask

    // Raise a request and hold it until the DUT is ready to take it
    task automatic applyStimulus(input int d, input bit r);
        int waitCyc = 0;
        @(negedge clk);
        reqDiv  = DW'(d);
        reqRamp = r;
        reqVld  = 1'b1;
        while (!reqRdy && waitCyc < 3000) begin
            @(negedge clk);
            waitCyc++;
        end
        if (!reqRdy) begin
            checkOutput("accept_timeout", 0, 1);
        end else begin
            pushExpected(modelDiv, d, r);
            modelDiv = d;
        end
        @(negedge clk);
        reqVld  = 1'b0;
        reqDiv  = DW'($urandom_range(0, 255));
        reqRamp = 1'($urandom_range(0, 1));
    endtask

    // Wait until the scoreboard has drained and the DUT is idle again
    task automatic waitIdle();
        int waitCyc = 0;
        while ((expBusy.size() != 0 || !reqRdy) && waitCyc < 5000) begin
            @(negedge clk);
            waitCyc++;
        end
        if (waitCyc >= 5000) checkOutput("idle_timeout", 0, 1);
    endtask

    // Monitor: on each toggle edge compare the sent value, its stability and
    // spacing; on each busy-to-idle fall compare the busy duration.
    initial begin : monitor
        logic          prevTog;
        logic [DW-1:0] prevDiv;
        int busyCnt;
        int cyc;
        int lastTog;
        prevTog = 1'b0;
        prevDiv = '0;
        busyCnt = 0;
        cyc     = 0;
        lastTog = -1;
        forever begin
            @(negedge clk);
            cyc++;
            if (inReset) begin
                prevTog = divTog;
                prevDiv = div;
                busyCnt = 0;
                lastTog = -1;
            end else begin
                checkOutput("rdy_vs_busy", int'(reqRdy), int'(!busy));
                if (divTog != prevTog) begin
                    checkOutput("div_stable_on_toggle", int'(div), int'(prevDiv));
                    if (expDiv.size() == 0) begin
                        checkOutput("unexpected_toggle", int'(div), -1);
                    end else begin
                        checkOutput("div_value", int'(div), expDiv.pop_front());
                    end
                    if (lastTog >= 0) checkOutput("toggle_spacing", cyc - lastTog, HOLD_CYC + 1);
                    lastTog = cyc;
                end
                if (busy) begin
                    busyCnt++;
                end else if (busyCnt > 0) begin
                    if (expBusy.size() == 0) checkOutput("unexpected_busy", busyCnt, 0);
                    else checkOutput("busy_cycles", busyCnt, expBusy.pop_front());
                    busyCnt = 0;
                    lastTog = -1;
                end
                prevTog = divTog;
                prevDiv = div;
            end
        end
    end

    // Directed scenarios, a mid-transfer reset, then randomized requests
    initial begin : stimulus
        int d;
        rstn    = 1'b0;
        reqVld  = 1'b0;
        reqDiv  = '0;
        reqRamp = 1'b0;
        #1;
        checkOutput("reset_div", int'(div), 0);
        checkOutput("reset_tog", int'(divTog), 0);
        checkOutput("reset_rdy", int'(reqRdy), 1);
        checkOutput("reset_busy", int'(busy), 0);
        #20;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1 inReset = 1'b0;

        // Direct write, ramp up by STEP, clamped ramp down, bypass not ramped
        applyStimulus(4, 0);
        waitIdle();
        applyStimulus(2, 0);
        waitIdle();
        applyStimulus(6, 1);
        waitIdle();
        applyStimulus(11, 0);
        waitIdle();
        applyStimulus(4, 1);
        waitIdle();
        applyStimulus(8, 0);
        waitIdle();
        applyStimulus(1, 1);
        waitIdle();

        // A request held while a ramp is in flight must wait for ready
        applyStimulus(2, 0);
        waitIdle();
        applyStimulus(6, 1);
        applyStimulus(5, 0);
        waitIdle();

        // Writing the current value still sends exactly one toggle
        applyStimulus(5, 1);
        waitIdle();
        applyStimulus(5, 0);
        waitIdle();

        // Reset in the middle of a ramp hold window
        applyStimulus(30, 1);
        repeat (5) @(negedge clk);
        #2;
        inReset = 1'b1;
        rstn    = 1'b0;
        #1;
        checkOutput("midreset_div", int'(div), 0);
        checkOutput("midreset_tog", int'(divTog), 0);
        checkOutput("midreset_rdy", int'(reqRdy), 1);
        expDiv.delete();
        expBusy.delete();
        modelDiv = 0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1 inReset = 1'b0;

        // Randomized traffic, occasionally back-to-back and with long ramps
        for (int i = 0; i < 30; i++) begin
            d = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 30);
            applyStimulus(d, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) != 0) waitIdle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        waitIdle();
        repeat (3) @(negedge clk);

        checkOutput("final_div", int'(div), modelDiv);
        checkOutput("leftover_div_expect", expDiv.size(), 0);
        checkOutput("leftover_busy_expect", expBusy.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the bench always ends
    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
